// File: rtl/mux4_scan_ctrl.sv
// Scan controller around the transistor-level 4:1 mux: steps the select code through
// all four channels, captures each synchronized result and hands the packed word out.
module mux4_scan_ctrl #(
    parameter int SETTLE_CYCLES = 3,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cont,
    input  logic       abort,
    input  logic       mux_result,
    input  logic       ready,
    output logic       s0,
    output logic       s1,
    output logic [3:0] data_out,
    output logic       valid,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state_q;
    logic [1:0]       sel_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       shreg_q;
    logic             sync0_q;
    logic             sync1_q;
    logic [3:0]       data_q;
    logic             valid_q;
    logic             busy_q;

    // Channel 3 never lands in shreg_q; it goes straight into the output word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            cnt_q   <= '0;
            shreg_q <= 3'd0;
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
            data_q  <= 4'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync0_q <= mux_result;
            sync1_q <= sync0_q;
            if (abort) begin
                state_q <= IDLE;
                sel_q   <= 2'd0;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        sel_q <= 2'd0;
                        if (start || cont) begin
                            cnt_q   <= RELOAD;
                            state_q <= SETTLE;
                            busy_q  <= 1'b1;
                        end
                    end
                    SETTLE: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else if (sel_q == 2'd3) begin
                            data_q  <= {sync1_q, shreg_q};
                            valid_q <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            case (sel_q)
                                2'd0:    shreg_q[0] <= sync1_q;
                                2'd1:    shreg_q[1] <= sync1_q;
                                default: shreg_q[2] <= sync1_q;
                            endcase
                            sel_q <= sel_q + 2'd1;
                            cnt_q <= RELOAD;
                        end
                    end
                    DONE: begin
                        if (ready) begin
                            valid_q <= 1'b0;
                            sel_q   <= 2'd0;
                            if (cont || start) begin
                                cnt_q   <= RELOAD;
                                state_q <= SETTLE;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        sel_q   <= 2'd0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign s0       = sel_q[0];
    assign s1       = sel_q[1];
    assign data_out = data_q;
    assign valid    = valid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Self-checking bench for mux4_scan_ctrl: a behavioural mux drives mux_result from the
// bench's channel values, and scans are checked for select stepping, latency and word.
module tb_mux4_scan_ctrl;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       cont;
    logic       abort;
    logic       ready;
    logic       s0;
    logic       s1;
    logic [3:0] data_out;
    logic       valid;
    logic       busy;
    logic [3:0] dIn;
    logic [1:0] selNow;
    logic       muxResult;

    int testsRun  = 0;
    int failCount = 0;

    typedef struct {
        logic [3:0] din;
        int         readyDelay;
        logic [3:0] expWord;
        int         expLat;
    } vec_t;

    vec_t vecs[4];

    assign selNow    = {s1, s0};
    assign muxResult = dIn[selNow];

    always #5 clk = ~clk;

    mux4_scan_ctrl #(.SETTLE_CYCLES(N), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cont       (cont),
        .abort      (abort),
        .mux_result (muxResult),
        .ready      (ready),
        .s0         (s0),
        .s1         (s1),
        .data_out   (data_out),
        .valid      (valid),
        .busy       (busy)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic co, input logic rd, input logic ab);
        start = st;
        cont  = co;
        ready = rd;
        abort = ab;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: channel k of the word is simply the value presented on mux input d_k.
    function automatic logic [3:0] modelWord(input logic [3:0] d);
        logic [3:0] w;
        for (int k = 0; k < 4; k++) w[k] = d[k];
        return w;
    endfunction

    function automatic int modelSel(input int t);
        return (t / N > 3) ? 3 : t / N;
    endfunction

    task automatic runScan(input logic [3:0] d, input int readyDelay,
                           input logic [3:0] expWord, input int expLat);
        int         lat;
        int         selErr;
        int         holdErr;
        logic [3:0] held;
        dIn = d;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("busyAfterStart", busy, 1);
        lat    = 0;
        selErr = 0;
        while (!valid && lat < expLat + 10) begin
            if (int'(selNow) != modelSel(lat)) selErr++;
            step();
            lat++;
        end
        checkOutput("selSequence", selErr, 0);
        checkOutput("latency", lat, expLat);
        checkOutput("word", data_out, expWord);
        checkOutput("selDone", selNow, 3);
        held    = data_out;
        holdErr = 0;
        for (int i = 0; i < readyDelay; i++) begin
            step();
            if (!valid || data_out != held || selNow != 2'd3) holdErr++;
        end
        checkOutput("backpressureHold", holdErr, 0);
        ready = 1'b1;
        step();
        ready = 1'b0;
        checkOutput("validCleared", valid, 0);
        checkOutput("idleBusy", busy, 0);
        checkOutput("idleSel", selNow, 0);
    endtask

    initial begin
        int         rises;
        int         riseCyc[2];
        logic [3:0] riseWord[2];
        int         cyc;
        logic       prevValid;
        logic [3:0] rd;

        vecs[0] = '{4'b1010, 10, 4'b1010, 4 * N};
        vecs[1] = '{4'b1111, 0, 4'b1111, 4 * N};
        vecs[2] = '{4'b0000, 2, 4'b0000, 4 * N};
        vecs[3] = '{4'b0110, 1, 4'b0110, 4 * N};

        rst_n = 1'b0;
        dIn   = 4'b0000;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            checkOutput("resetIdle", int'({s1, s0, valid, busy, data_out}), 0);
            step();
        end

        for (int i = 0; i < 4; i++) begin
            runScan(vecs[i].din, vecs[i].readyDelay, vecs[i].expWord, vecs[i].expLat);
        end

        // Continuous mode with ready held high: two words, the second from new inputs.
        dIn       = 4'b1010;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        rises     = 0;
        cyc       = 0;
        prevValid = 1'b0;
        while (rises < 2 && cyc < 80) begin
            step();
            cyc++;
            if (valid && !prevValid) begin
                riseCyc[rises]  = cyc;
                riseWord[rises] = data_out;
                if (rises == 0) dIn = 4'b0101;
                else cont = 1'b0;
                rises++;
            end
            prevValid = valid;
        end
        checkOutput("contRises", rises, 2);
        if (rises == 2) begin
            checkOutput("contWord0", riseWord[0], 4'b1010);
            checkOutput("contWord1", riseWord[1], 4'b0101);
            checkOutput("contGap", riseCyc[1] - riseCyc[0], 4 * N + 1);
        end
        step();
        ready = 1'b0;
        step();
        checkOutput("contStopBusy", busy, 0);
        checkOutput("contStopValid", valid, 0);

        // Abort at E+5: back to idle, previous word retained.
        dIn = 4'b0011;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        checkOutput("abortSel", selNow, 0);
        checkOutput("abortValid", valid, 0);
        checkOutput("abortBusy", busy, 0);
        checkOutput("abortKeepsWord", data_out, 4'b0101);
        repeat (3) step();
        checkOutput("abortStaysIdle", int'({valid, busy}), 0);
        runScan(4'b0011, 0, 4'b0011, 4 * N);

        // Asynchronous reset between edges E+7 and E+8.
        dIn = 4'b1100;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (7) step();
        checkOutput("preResetSel", selNow, 2);
        rst_n = 1'b0;
        #1;
        checkOutput("asyncResetSel", selNow, 0);
        checkOutput("asyncResetBusy", busy, 0);
        checkOutput("asyncResetValid", valid, 0);
        checkOutput("asyncResetWord", data_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            if (valid || busy) checkOutput("postResetIdle", int'({valid, busy}), 0);
        end
        checkOutput("postResetEnd", int'({valid, busy}), 0);
        runScan(4'b1100, 0, 4'b1100, 4 * N);

        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) step();
            rd = 4'($urandom);
            runScan(rd, int'($urandom_range(0, 4)), modelWord(rd), 4 * N);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/mux4_scan_ctrl.md
# mux4_scan_ctrl

Clocked scan controller that drives the select lines of the transistor-level 4:1 mux and consumes its single-bit result. It steps the select code through all four channels, waits a programmable settle time on each, synchronizes and captures the mux output, and packs the four samples into a 4-bit word. The word is delivered with a valid/ready handshake. The block sits directly around the mux: upstream of its s0/s1 inputs and downstream of its result output.

## Interface
- SETTLE_CYCLES, default 3: cycles from a select change to capture of that channel; legal range 3..255.
- CNT_W, default 8: width of the settle counter; must satisfy SETTLE_CYCLES <= 2^CNT_W - 1.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- start  in  1  request one scan; sampled only in IDLE, or in DONE on a handshake edge.
- cont  in  1  continuous mode; when high, a new scan begins automatically after each handshake.
- abort  in  1  synchronous abort; returns to IDLE from any state.
- mux_result  in  1  mux output; treated as asynchronous.
- s0  out  1  mux select LSB; registered.
- s1  out  1  mux select MSB; registered. Channel index is {s1,s0}.
- data_out  out  4  captured word; data_out[i] is the value of channel d_i.
- valid  out  1  data_out holds a completed scan.
- ready  in  1  consumer accepts data_out.
- busy  out  1  high in SETTLE and DONE.

## Operation
- Input path: mux_result passes through a 2-flop synchronizer (sync0, then sync1). Captures use sync1 only.
- States:
  - IDLE: s1s0=00, busy=0. If start=1 or cont=1: sel<=00, cnt<=SETTLE_CYCLES-1, go to SETTLE.
  - SETTLE: if cnt!=0, cnt<=cnt-1.
    - If cnt==0: shreg[sel]<=sync1.
    - If sel==3: data_out<={sync1, shreg[2:0]}, valid<=1, go to DONE.
    - Otherwise: sel<=sel+1, cnt<=SETTLE_CYCLES-1.
  - DONE: valid=1; s1s0 stays at 11.
    - On an edge with ready=1: valid<=0.
    - If cont or start: sel<=00, cnt reload, go to SETTLE. Otherwise go to IDLE.
- start in SETTLE is ignored; there is no queueing.
- abort at any edge: state<=IDLE, sel<=00, valid<=0. data_out keeps its previous value.
- Priority at an edge: abort > handshake > start.
- data_out changes only on the completion edge and is stable while valid=1.
- ready while valid=0 has no effect.
- Reset: state=IDLE; s0=s1=0; sel=0; cnt=0; shreg=0; sync0=sync1=0; data_out=0; valid=0; busy=0.
  - Reset mid-scan discards the partial word.
  - After rst_n deasserts, the first edge can accept start.

## Timing
- Let N=SETTLE_CYCLES and let start be accepted at edge E.
- s1s0 = 00 after E, 01 after E+N, 10 after E+2N, 11 after E+3N.
- Channel k is captured at edge E+(k+1)N. sync1 at that edge reflects mux_result sampled at edge E+(k+1)N-2, which is at least 1 cycle after the select change.
- valid rises after edge E+4N. Scan latency is 4N cycles; N=3 gives 12.
- Handshake edge H in continuous mode: s1s0=00 and valid=0 after H, so the next valid comes after H+4N.
- Maximum throughput: one word per 4N+1 cycles when ready is held high.
- busy is registered and matches state: high from after E until the edge that leaves DONE for IDLE.
- cnt never underflows; sel wraps only by reload to 00, never by increment past 3.

## Test plan
- Reset and idle: rst_n low, then high, start=0 for 20 cycles -> s0=s1=0, valid=0, data_out=0, busy=0 throughout.
- Single scan, N=3: bench mux model with d3..d0=1010; start pulse at edge E -> s1s0 steps 00/01/10/11 at E, E+3, E+6, E+9; valid=1 and data_out=4'b1010 after E+12.
- Backpressure: ready low for 10 cycles after valid -> data_out stays 4'b1010 and s1s0 stays 11; with ready=1 at edge H, valid=0 and state IDLE after H.
- Continuous mode: cont=1, ready=1, inputs changed to 0101 during the second scan -> words 1010 then 0101, consecutive valid rises 13 cycles apart.
- Abort mid-scan: abort at E+5 -> IDLE, s1s0=00, valid=0, data_out keeps its prior word; a restart yields a full correct word.
- Async reset mid-scan: rst_n low between edges at E+7 -> all outputs 0 immediately, not waiting for the next edge; no valid until a new start.
